// File: rtl/step_dir_decoder_pkg.sv
// Shared definitions for the step/dir receive decoder: FSM encoding and
// error flag bit positions.
package step_dir_decoder_pkg;

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    localparam int ERR_SETUP = 0;
    localparam int ERR_HOLD  = 1;
    localparam int ERR_WIDTH = 2;
    localparam int ERR_W     = 3;

endpackage

// File: rtl/step_dir_decoder_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, followed by a one-flop
// delayed copy used to flag rising and falling edges of the synchronised value.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver for one axis: tracks signed position, measures step period
// and flags driver timing violations (dir setup, dir hold, step pulse width).
module step_dir_decoder
    import step_dir_decoder_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int POS_W         = 32,
    parameter int PER_W         = 32,
    parameter int MIN_DIR_SETUP = 4,
    parameter int MIN_STEP_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             enable,
    input  logic             set_pos,
    input  logic [POS_W-1:0] pos_val,
    input  logic             snapshot,
    input  logic             clear_err,
    output logic [POS_W-1:0] position,
    output logic [POS_W-1:0] snap_position,
    output logic [PER_W-1:0] snap_period,
    output logic [PER_W-1:0] last_period,
    output logic             period_valid,
    output logic             step_stb,
    output logic             dir_out,
    output logic [2:0]       err_flags
);

    localparam int SET_W = $clog2(MIN_DIR_SETUP + 1);
    localparam int HI_W  = $clog2(MIN_STEP_HIGH + 1);
    localparam logic [SET_W-1:0]        SET_MAX = SET_W'(MIN_DIR_SETUP);
    localparam logic [HI_W-1:0]         HI_MIN  = HI_W'(MIN_STEP_HIGH);
    localparam logic signed [POS_W-1:0] POS_ONE = 1;

    function automatic logic [PER_W-1:0] per_sat_inc(input logic [PER_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [SET_W-1:0] setup_sat_inc(input logic [SET_W-1:0] v);
        return (v >= SET_MAX) ? v : v + 1'b1;
    endfunction

    logic step_s, step_rise, step_fall;
    logic dir_s, dir_rise, dir_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (step_in),
        .dout  (step_s),
        .rise  (step_rise),
        .fall  (step_fall)
    );

    // dir only needs its synchronised value; its edges serve as the change flag
    sync_edge #(.STAGES(SYNC_STAGES)) u_dir_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (dir_in),
        .dout  (dir_s),
        .rise  (dir_rise),
        .fall  (dir_fall)
    );

    logic [0:0]              state_q,    state_d;
    logic [HI_W-1:0]         high_q,     high_d;
    logic [SET_W-1:0]        setup_q,    setup_d;
    logic signed [POS_W-1:0] pos_q,      pos_d;
    logic [PER_W-1:0]        per_cnt_q,  per_cnt_d;
    logic [PER_W-1:0]        last_per_q, last_per_d;
    logic                    per_vld_q,  per_vld_d;
    logic                    meas_q,     meas_d;
    logic                    stb_q,      stb_d;
    logic [ERR_W-1:0]        err_q,      err_d;
    logic [POS_W-1:0]        snap_pos_q, snap_pos_d;
    logic [PER_W-1:0]        snap_per_q, snap_per_d;

    logic             dir_chg;
    logic             accept;
    logic [SET_W-1:0] setup_eff;
    logic [PER_W-1:0] per_inc;
    logic [ERR_W-1:0] err_evt;

    always_comb begin
        dir_chg   = dir_rise | dir_fall;
        // a dir change in the same cycle as a step rise counts as zero setup
        setup_eff = dir_chg ? '0 : setup_q;
        setup_d   = setup_sat_inc(setup_eff);
        accept    = enable && (state_q == ST_LOW) && step_rise;

        err_evt            = '0;
        err_evt[ERR_SETUP] = accept && (setup_eff < SET_MAX);
        err_evt[ERR_HOLD]  = enable && (state_q == ST_HIGH) && dir_chg;
        err_evt[ERR_WIDTH] = enable && (state_q == ST_HIGH) && step_fall && (high_q < HI_MIN);

        state_d = state_q;
        high_d  = high_q;
        if (!enable) begin
            state_d = ST_LOW;
        end else if (state_q == ST_LOW) begin
            if (accept) begin
                state_d = ST_HIGH;
                high_d  = HI_W'(1);
            end
        end else begin
            if (step_fall) begin
                state_d = ST_LOW;
            end else if (high_q < HI_MIN) begin
                high_d = high_q + 1'b1;
            end
        end

        per_inc    = per_sat_inc(per_cnt_q);
        per_cnt_d  = per_inc;
        pos_d      = pos_q;
        last_per_d = last_per_q;
        per_vld_d  = per_vld_q;
        meas_d     = meas_q;
        if (set_pos) begin
            pos_d     = $signed(pos_val);
            per_cnt_d = '0;
            per_vld_d = 1'b0;
            meas_d    = 1'b0;
        end else if (accept) begin
            pos_d      = dir_s ? pos_q + POS_ONE : pos_q - POS_ONE;
            last_per_d = per_inc;
            per_cnt_d  = '0;
            meas_d     = 1'b1;
            if (meas_q) begin
                per_vld_d = 1'b1;
            end
        end

        stb_d      = accept;
        err_d      = (clear_err ? '0 : err_q) | err_evt;
        snap_pos_d = snapshot ? pos_d : snap_pos_q;
        snap_per_d = snapshot ? last_per_d : snap_per_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOW;
            high_q     <= '0;
            setup_q    <= '0;
            pos_q      <= '0;
            per_cnt_q  <= '0;
            last_per_q <= '0;
            per_vld_q  <= 1'b0;
            meas_q     <= 1'b0;
            stb_q      <= 1'b0;
            err_q      <= '0;
            snap_pos_q <= '0;
            snap_per_q <= '0;
        end else begin
            state_q    <= state_d;
            high_q     <= high_d;
            setup_q    <= setup_d;
            pos_q      <= pos_d;
            per_cnt_q  <= per_cnt_d;
            last_per_q <= last_per_d;
            per_vld_q  <= per_vld_d;
            meas_q     <= meas_d;
            stb_q      <= stb_d;
            err_q      <= err_d;
            snap_pos_q <= snap_pos_d;
            snap_per_q <= snap_per_d;
        end
    end

    assign position      = pos_q;
    assign snap_position = snap_pos_q;
    assign snap_period   = snap_per_q;
    assign last_period   = last_per_q;
    assign period_valid  = per_vld_q;
    assign step_stb      = stb_q;
    assign dir_out       = dir_s;
    assign err_flags     = err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: directed scenarios plus random pulse trains,
// compared against a timing-rule model of the step/dir protocol.
module tb_step_dir_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_in, dir_in, enable, set_pos, snapshot, clear_err;
    logic [31:0] pos_val;
    logic [31:0] position, snap_position, snap_period, last_period;
    logic        period_valid, step_stb, dir_out;
    logic [2:0]  err_flags;

    step_dir_decoder dut (
        .clk           (clk),
        .rst           (rst_n),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .enable        (enable),
        .set_pos       (set_pos),
        .pos_val       (pos_val),
        .snapshot      (snapshot),
        .clear_err     (clear_err),
        .position      (position),
        .snap_position (snap_position),
        .snap_period   (snap_period),
        .last_period   (last_period),
        .period_valid  (period_valid),
        .step_stb      (step_stb),
        .dir_out       (dir_out),
        .err_flags     (err_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;

    always @(posedge clk) if (step_stb === 1'b1) stb_cnt++;

    // Model state: time is counted in clock cycles at the input pins
    int          tcyc = 0;
    logic [31:0] m_pos = '0;
    logic [2:0]  m_err = '0;
    int          m_n = 0;
    int          m_prev = 0;
    int          m_lastper = 0;
    int          m_stb = 0;
    int          m_dchg = 0;
    logic        m_en = 1'b1;

    logic        rd;
    int          rsu, rhi, rlo, rsel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            tcyc++;
            #1;
        end
    endtask

    task automatic set_dir(input logic d);
        if (d !== dir_in) begin
            dir_in = d;
            m_dchg = tcyc;
        end
    endtask

    // Called when step_in is driven high: applies the protocol rules
    task automatic model_rise();
        if (!m_en) return;
        m_stb++;
        if (tcyc - m_dchg < 4) m_err[0] = 1'b1;
        m_pos = dir_in ? m_pos + 32'd1 : m_pos - 32'd1;
        if (m_n > 0) m_lastper = tcyc - m_prev;
        m_prev = tcyc;
        m_n++;
    endtask

    task automatic pulse(input logic d, input int su, input int hi, input int lo);
        set_dir(d);
        tick(su);
        step_in = 1'b1;
        model_rise();
        tick(hi);
        step_in = 1'b0;
        if (m_en && hi < 2) m_err[2] = 1'b1;
        tick(lo);
    endtask

    task automatic do_set_pos(input logic [31:0] v);
        set_pos = 1'b1;
        pos_val = v;
        tick(1);
        set_pos = 1'b0;
        m_pos = v;
        m_n = 0;
    endtask

    task automatic do_clear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        m_err = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pos"}, position, m_pos);
        chk({tag, "_err"}, err_flags, m_err);
        chk({tag, "_vld"}, period_valid, (m_n >= 2));
        if (m_n >= 2) chk({tag, "_per"}, last_period, m_lastper);
        chk({tag, "_stbcnt"}, stb_cnt, m_stb);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; step_in = 1'b0; dir_in = 1'b1; enable = 1'b1;
        set_pos = 1'b0; snapshot = 1'b0; clear_err = 1'b0; pos_val = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pos", position, 0);
        chk("rst_snappos", snap_position, 0);
        chk("rst_snapper", snap_period, 0);
        chk("rst_per", last_period, 0);
        chk("rst_vld", period_valid, 0);
        chk("rst_stb", step_stb, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_err", err_flags, 0);
        tick(2);
        rst_n = 1'b1;
        m_dchg = tcyc;
        tick(10);

        // 10 steps, dir=1, high 5, period 20; first step latency
        step_in = 1'b1;
        model_rise();
        tick(2);
        chk("lat_pre_stb", step_stb, 0);
        chk("lat_pre_pos", position, 0);
        tick(1);
        chk("lat_stb", step_stb, 1);
        chk("lat_pos", position, 1);
        tick(1);
        chk("lat_stb_one_cycle", step_stb, 0);
        tick(1);
        step_in = 1'b0;
        tick(15);
        for (int i = 0; i < 9; i++) pulse(1'b1, 0, 5, 15);
        check_state("train");
        chk("train_pos10", position, 10);
        chk("train_per20", last_period, 20);
        chk("train_dirout", dir_out, 1);

        // Wrap-around forward and back
        do_set_pos(32'h7FFF_FFFF);
        pulse(1'b1, 0, 3, 5);
        chk("wrap_up", position, 32'h8000_0000);
        pulse(1'b0, 10, 3, 5);
        pulse(1'b0, 0, 3, 5);
        check_state("wrap");
        chk("wrap_down", position, 32'h7FFF_FFFE);

        // Dir setup violation: counted with new dir, flag set, then cleared
        pulse(1'b1, 2, 4, 6);
        check_state("setup");
        chk("setup_flag", err_flags, 3'b001);
        do_clear();
        chk("setup_clr", err_flags, 3'b000);

        // Dir hold violation
        tick(5);
        step_in = 1'b1;
        model_rise();
        tick(2);
        set_dir(~dir_in);
        m_err[1] = 1'b1;
        tick(3);
        step_in = 1'b0;
        tick(10);
        check_state("hold");
        chk("hold_flag", err_flags, 3'b010);

        // One-cycle pulse: width violation
        pulse(dir_in, 5, 1, 10);
        check_state("width");
        chk("width_flag", err_flags, 3'b110);

        // clear_err coincident with a new width violation
        step_in = 1'b1;
        model_rise();
        tick(1);
        step_in = 1'b0;
        tick(2);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        m_err = 3'b100;
        tick(3);
        check_state("clr_coinc");
        chk("clr_coinc_flag", err_flags, 3'b100);
        do_clear();
        chk("clr_final", err_flags, 3'b000);

        // set_pos and snapshot coincident with an accepted step
        tick(5);
        step_in = 1'b1;
        tick(2);
        set_pos = 1'b1;
        pos_val = 32'd100;
        snapshot = 1'b1;
        tick(1);
        set_pos = 1'b0;
        snapshot = 1'b0;
        m_stb++;
        m_pos = 32'd100;
        m_n = 0;
        chk("sp_pos", position, 100);
        chk("sp_snappos", snap_position, 100);
        chk("sp_snapper", snap_period, m_lastper);
        chk("sp_vld", period_valid, 0);
        chk("sp_stb", step_stb, 1);
        tick(2);
        step_in = 1'b0;
        tick(10);
        pulse(1'b0, 0, 3, 5);
        chk("sp_vld_first", period_valid, 0);
        pulse(1'b0, 0, 3, 5);
        check_state("sp_after");

        // Snapshot alone captures current values
        snapshot = 1'b1;
        tick(1);
        snapshot = 1'b0;
        chk("snap_pos", snap_position, m_pos);
        chk("snap_per", snap_period, m_lastper);

        // enable=0: pulses ignored, no checks
        enable = 1'b0;
        m_en = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) pulse(i[0], 0, (i == 2) ? 1 : 3, 5);
        tick(3);
        check_state("dis");
        enable = 1'b1;
        m_en = 1'b1;
        tick(5);

        // Random pulse trains
        for (int i = 0; i < 60; i++) begin
            rd   = 1'($urandom_range(0, 1));
            rsu  = $urandom_range(0, 7);
            rhi  = $urandom_range(1, 6);
            rlo  = $urandom_range(1, 8);
            pulse(rd, rsu, rhi, rlo);
            tick(3);
            check_state("rnd");
            chk("rnd_dir", dir_out, dir_in);
            rsel = $urandom_range(0, 9);
            if (rsel == 0) do_clear();
            else if (rsel == 1) do_set_pos($urandom);
        end

        // Asynchronous reset mid-pulse, then re-detection as the chain fills
        set_dir(1'b1);
        tick(8);
        step_in = 1'b1;
        model_rise();
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("arst_pos", position, 0);
        chk("arst_stb", step_stb, 0);
        chk("arst_err", err_flags, 0);
        chk("arst_vld", period_valid, 0);
        chk("arst_per", last_period, 0);
        chk("arst_snappos", snap_position, 0);
        chk("arst_dir", dir_out, 0);
        tick(2);
        rst_n = 1'b1;
        m_pos = '0;
        m_err = '0;
        m_n = 0;
        m_dchg = tcyc;
        model_rise();
        tick(5);
        check_state("arst_after");
        chk("arst_after_pos", position, 1);
        chk("arst_after_err", err_flags, 3'b001);
        step_in = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
